fir_delay_line_ctrl: RTL

- Write/read sequencer for the FIR lowpass filter's sample delay line.
- Sits between the sample source and the MAC datapath; drives the ports of the externally instantiated dual_port_RAM (M entries of N bits) as a circular buffer.
- Per accepted input sample: writes the sample, then streams all M stored samples, newest first, as a tap sequence with a coefficient index.
- The MAC consumes the tap stream directly.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_delay_line_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fir_pkg.sv
// Shared FIR filter definitions: sample width, tap count and delay-line sequencer states.
// Also used by the MAC datapath and the coefficient ROM.
package fir_pkg;

    localparam int SAMPLE_W = 8;
    localparam int TAPS     = 32;
    localparam int ADDR_W   = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        CLEAR = 2'd3
    } fir_state_e;

endpackage

// File: rtl/fir_delay_line_ctrl.sv
// Circular-buffer write/read sequencer for the FIR sample delay line (external dual-port RAM).
// Optional FIR_DELAY_LINE_ZERO_INIT_EN: zero-fill the RAM after reset for a zero-history start.
module fir_delay_line_ctrl
    import fir_pkg::*;
#(
    parameter int N = SAMPLE_W,
    parameter int M = TAPS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_sample,
    output logic                 ram_we,
    output logic [$clog2(M)-1:0] ram_wr_addr,
    output logic [N-1:0]         ram_wr_din,
    output logic [$clog2(M)-1:0] ram_rd_addr,
    input  logic [N-1:0]         ram_rd_dout,
    output logic                 tap_valid,
    output logic [N-1:0]         tap_data,
    output logic [$clog2(M)-1:0] tap_idx,
    output logic                 tap_first,
    output logic                 tap_last
);

    localparam int AW = $clog2(M);
    localparam logic [AW-1:0] K_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] K_ONE  = AW'(1);
    localparam logic [AW-1:0] K_LAST = AW'(M - 1);

`ifdef FIR_DELAY_LINE_ZERO_INIT_EN
    localparam fir_state_e RESET_STATE = CLEAR;
`else
    localparam fir_state_e RESET_STATE = IDLE;
`endif

    fir_state_e     state_r;
    logic [AW-1:0]  wp_r;
    logic [AW-1:0]  base_r;
    logic [AW-1:0]  k_r;
    logic           tap_valid_r;
    logic           tap_first_r;
    logic           tap_last_r;
    logic [AW-1:0]  tap_idx_r;
    logic           accept_s;
    logic           rd_issue_s;

    assign in_ready   = (state_r == IDLE);
    assign accept_s   = in_valid && in_ready;
    assign rd_issue_s = (state_r == READ);

    // RAM port drive: the sample write happens in the handshake cycle itself
    always_comb begin
        ram_we      = 1'b0;
        ram_wr_addr = wp_r;
        ram_wr_din  = in_sample;
        ram_rd_addr = K_ZERO;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    ram_we = 1'b1;
                end else begin
                    ram_we = 1'b0;
                end
            end
            READ: begin
                // newest first: walk backwards from the just-written slot, wrapping mod M
                ram_rd_addr = base_r - k_r;
            end
`ifdef FIR_DELAY_LINE_ZERO_INIT_EN
            CLEAR: begin
                ram_we      = 1'b1;
                ram_wr_addr = k_r;
                ram_wr_din  = {N{1'b0}};
            end
`endif
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // Sequencer FSM: write pointer, read base and tap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_STATE;
            wp_r    <= K_ZERO;
            base_r  <= K_ZERO;
            k_r     <= K_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        base_r  <= wp_r;
                        wp_r    <= wp_r + K_ONE;
                        k_r     <= K_ZERO;
                        state_r <= READ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (k_r == K_LAST) begin
                        k_r     <= K_ZERO;
                        state_r <= DRAIN;
                    end else begin
                        k_r     <= k_r + K_ONE;
                    end
                end
                DRAIN: begin
                    state_r <= IDLE;
                end
                CLEAR: begin
`ifdef FIR_DELAY_LINE_ZERO_INIT_EN
                    if (k_r == K_LAST) begin
                        k_r     <= K_ZERO;
                        state_r <= IDLE;
                    end else begin
                        k_r     <= k_r + K_ONE;
                    end
`else
                    k_r     <= K_ZERO;
                    state_r <= IDLE;
`endif
                end
                default: begin
                    k_r     <= K_ZERO;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Tap sideband delayed one cycle to line up with the registered RAM read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_valid_r <= 1'b0;
            tap_first_r <= 1'b0;
            tap_last_r  <= 1'b0;
            tap_idx_r   <= K_ZERO;
        end else begin
            tap_valid_r <= rd_issue_s;
            tap_first_r <= rd_issue_s && (k_r == K_ZERO);
            tap_last_r  <= rd_issue_s && (k_r == K_LAST);
            tap_idx_r   <= rd_issue_s ? k_r : K_ZERO;
        end
    end

    assign tap_valid = tap_valid_r;
    assign tap_first = tap_first_r;
    assign tap_last  = tap_last_r;
    assign tap_idx   = tap_idx_r;
    assign tap_data  = ram_rd_dout;

endmodule
